// File: rtl/RSA_pkg.sv
// RSA_pkg: shared RSA widths and types, plus the input deserializer word and state types
package RSA_pkg;

    localparam int MOD_WIDTH  = 256;
    localparam int WORD_WIDTH = 32;

    typedef logic [MOD_WIDTH-1:0]  KeyType;
    typedef logic [WORD_WIDTH-1:0] WordType;

    typedef struct packed {
        KeyType modulus;
        KeyType key;
        KeyType msg;
    } RSAModIn;

    typedef enum logic {
        COLLECT,
        HOLD
    } DeserState;

endpackage

// File: rtl/rsa_in_deserializer_if.sv
// rsa_in_deserializer_if: word-stream input and packet output handshakes of the deserializer
interface rsa_in_deserializer_if
    import RSA_pkg::*;
#(
    parameter int WORD_WIDTH = RSA_pkg::WORD_WIDTH
);

    logic                  i_valid;
    logic                  i_ready;
    logic [WORD_WIDTH-1:0] i_word;
    logic                  o_valid;
    logic                  o_ready;
    RSAModIn               o_out;
    logic                  o_err;

    modport slave (
        input  i_valid, i_word, o_ready,
        output i_ready, o_valid, o_out, o_err
    );

    modport master (
        output i_valid, i_word, o_ready,
        input  i_ready, o_valid, o_out, o_err
    );

endinterface

// File: rtl/rsa_in_deserializer.sv
// rsa_in_deserializer: assembles msg/key/modulus words into one RSAModIn packet.
// Optional build macro RSA_IN_DESERIALIZER_ODD_CHECK_EN drops packets with an even modulus.
module rsa_in_deserializer
    import RSA_pkg::*;
#(
    parameter int WORD_WIDTH = RSA_pkg::WORD_WIDTH
) (
    input logic                   clk,
    input logic                   rst,
    rsa_in_deserializer_if.slave  bus
);

    localparam int WORDS_PER_FIELD = MOD_WIDTH / WORD_WIDTH;
    localparam int NUM_WORDS       = 3 * WORDS_PER_FIELD;
    localparam int CW              = $clog2(NUM_WORDS);

    DeserState              state;
    DeserState              state_nx;
    logic [CW-1:0]          cnt;
    logic [3*MOD_WIDTH-1:0] sreg;
    logic                   acc;
    logic                   last;
    logic                   pass;

    assign acc  = bus.i_valid && bus.i_ready;
    assign last = cnt == CW'(NUM_WORDS - 1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= COLLECT;
        else      state <= state_nx;
    end

    // Next state: leave COLLECT on an accepted final word of a valid packet, leave HOLD on transfer
    always_comb begin
        state_nx = state;
        if (state == COLLECT) state_nx = (acc && last && pass) ? HOLD : COLLECT;
        else                  state_nx = bus.o_ready ? COLLECT : HOLD;
    end

    // Handshake outputs come from the state alone, so no valid/ready combinational loop exists
    always_comb begin
        bus.i_ready = state == COLLECT;
        bus.o_valid = state == HOLD;
    end

    // Word counter wraps to 0 after the final word, whether or not the packet is kept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     cnt <= '0;
        else if (acc) cnt <= last ? '0 : cnt + CW'(1);
    end

    // Shift register: new words enter at the top, so the first word ends up at bit 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     sreg <= '0;
        else if (acc) sreg <= {bus.i_word, sreg[3*MOD_WIDTH-1:WORD_WIDTH]};
    end

    assign bus.o_out.msg     = sreg[MOD_WIDTH-1:0];
    assign bus.o_out.key     = sreg[2*MOD_WIDTH-1:MOD_WIDTH];
    assign bus.o_out.modulus = sreg[3*MOD_WIDTH-1:2*MOD_WIDTH];

`ifdef RSA_IN_DESERIALIZER_ODD_CHECK_EN
    logic odd;
    logic err;

    // Capture modulus parity from its lowest word; flag a dropped packet for one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            odd <= 1'b0;
            err <= 1'b0;
        end else begin
            if (acc && cnt == CW'(2 * WORDS_PER_FIELD)) odd <= bus.i_word[0];
            err <= acc && last && !odd;
        end
    end

    assign pass      = odd;
    assign bus.o_err = err;
`else
    assign pass      = 1'b1;
    assign bus.o_err = 1'b0;
`endif

endmodule
